// File: rtl/reverser_serial_unit.sv
// rtl/reverser_serial_unit.sv - handshaked bit-serial operand reverser for the ALSU datapath
//
// Accepts one operand pair per transaction, keeps A or B (chosen by Sel) and
// shifts it out LSB-first into the MSB-first result register, one bit per clock.
// The finished result is held on a valid/ready port until it is consumed.
//
// Optional feature macro: REVERSER_PARITY_EN (adds the Parity output).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   A, B       operands, sampled only on the acceptance edge
//   Sel        source select at acceptance: 0 = A, 1 = B
//   In_Valid   requester has an operand pair
//   In_Ready   block can accept (IDLE only)
//   Out        result register, meaningful while Out_Valid = 1
//   Out_Valid  result available, held until consumed
//   Out_Ready  consumer takes the result
//   Busy       high in SHIFT and DONE
//   Parity     XOR of the completed result (REVERSER_PARITY_EN only)

module reverser_serial_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Busy
`ifdef REVERSER_PARITY_EN
  ,
  output logic             Parity
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   src;
  logic [CNT_W-1:0]   count;
  logic               last_shift;

  assign last_shift = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs are decoded from state only, so no input reaches an
  // output combinationally.
  always_comb begin
    state_nxt = state;
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    Busy      = 1'b0;
    case (state)
      IDLE: begin
        In_Ready = 1'b1;
        if (In_Valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        Busy = 1'b1;
        if (last_shift) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        Busy      = 1'b1;
        Out_Valid = 1'b1;
        if (Out_Ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Source LSB enters the result at bit 0 and is pushed up, so after WIDTH
  // shifts source bit i sits at Out[WIDTH-1-i].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src   <= '0;
      Out   <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (In_Valid) begin
            src   <= Sel ? B : A;
            Out   <= '0;
            count <= '0;
          end
        end
        SHIFT: begin
          Out <= {Out[WIDTH-2:0], src[0]};
          src <= src >> 1;
          // Saturate so a power-of-two WIDTH never wraps the counter to 0.
          if (!last_shift) begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef REVERSER_PARITY_EN
  // Parity is taken from the value Out is about to hold after the final shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Parity <= 1'b0;
    end else if (state == IDLE && In_Valid) begin
      Parity <= 1'b0;
    end else if (state == SHIFT && last_shift) begin
      Parity <= ^{Out[WIDTH-2:0], src[0]};
    end
  end
`endif

endmodule

// File: tb/tb_reverser_serial_unit.sv
// tb/tb_reverser_serial_unit.sv - self-checking bench for reverser_serial_unit

module tb_reverser_serial_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Sel;
  logic         In_Valid;
  logic         In_Ready;
  logic [W-1:0] Out;
  logic         Out_Valid;
  logic         Out_Ready;
  logic         Busy;
`ifdef REVERSER_PARITY_EN
  logic         Parity;
`endif

  int vectors    = 0;
  int miscompares = 0;

  reverser_serial_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Sel       (Sel),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Out       (Out),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Busy      (Busy)
`ifdef REVERSER_PARITY_EN
    ,
    .Parity    (Parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[W-1-i] = v[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction, starting with the DUT idle and time just after an edge.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                         input int hold, input bit noise);
    logic [W-1:0] exp;
    int lat;
    exp = rev(sel ? b : a);
    A = a; B = b; Sel = sel; In_Valid = 1'b1; Out_Ready = (hold == 0);
    @(posedge clk); #1;
    if (!noise) In_Valid = 1'b0;
    check("accept_busy", 32'(Busy), 1);
    lat = 0;
    while (!Out_Valid && lat < 20) begin
      if (noise) begin
        A = W'($urandom); B = W'($urandom); Sel = 1'($urandom);
        check("in_ready_low", 32'(In_Ready), 0);
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), W);
    check("out", 32'(Out), 32'(exp));
`ifdef REVERSER_PARITY_EN
    check("parity", 32'(Parity), 32'($countones(exp) % 2));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(Out_Valid), 1);
      check("hold_out", 32'(Out), 32'(exp));
    end
    Out_Ready = 1'b1;
    @(posedge clk); #1;
    In_Valid = 1'b0; Out_Ready = 1'b0;
    check("consumed_valid", 32'(Out_Valid), 0);
    check("consumed_ready", 32'(In_Ready), 1);
    if (noise) begin
      @(posedge clk); #1;
      check("no_second_accept", 32'(In_Ready), 1);
    end
  endtask

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] e;
    int pushed, got, cyc, last_t;

    rst = 1'b1; A = '0; B = '0; Sel = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(In_Ready), 1);
    check("rst_out_valid", 32'(Out_Valid), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_out", 32'(Out), 0);
`ifdef REVERSER_PARITY_EN
    check("rst_parity", 32'(Parity), 0);
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_txn(4'b0001, 4'b0000, 1'b0, 0, 1'b0);
    run_txn(4'b0000, 4'b0111, 1'b1, 0, 1'b0);
    run_txn(4'b0110, 4'b0000, 1'b0, 0, 1'b0);
    run_txn(4'b0000, 4'b1001, 1'b1, 0, 1'b0);
    run_txn(4'b1010, 4'b0000, 1'b0, 0, 1'b0);
    run_txn(4'b1100, 4'b0000, 1'b0, 10, 1'b1);
    // Involution: the reversed value reverses back
    run_txn(rev(4'b1101), 4'b0000, 1'b0, 0, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 12; n++) begin
      run_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(3)), 1'($urandom));
    end

    // Back-to-back with In_Valid and Out_Ready held high
    In_Valid = 1'b1; Out_Ready = 1'b1; Sel = 1'b0;
    pushed = 0; got = 0; cyc = 0; last_t = -1;
    while (got < 8 && cyc < 200) begin
      if (In_Ready) begin
        if (pushed < 8) begin
          A = W'($urandom);
          q.push_back(A);
          pushed++;
        end else begin
          In_Valid = 1'b0;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (Out_Valid) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          check("b2b_out", 32'(Out), 32'(rev(e)));
        end else begin
          check("b2b_extra_result", 1, 0);
        end
        if (last_t >= 0) check("b2b_spacing", 32'(cyc - last_t), W + 2);
        last_t = cyc;
        got++;
      end
    end
    check("b2b_count", 32'(got), 8);
    In_Valid = 1'b0;
    @(posedge clk); #1;
    Out_Ready = 1'b0;
    check("b2b_idle", 32'(In_Ready), 1);

    // Reset abort after two SHIFT cycles
    A = 4'b1010; Sel = 1'b0; In_Valid = 1'b1;
    @(posedge clk); #1;
    In_Valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out", 32'(Out), 0);
    check("abort_valid", 32'(Out_Valid), 0);
    check("abort_in_ready", 32'(In_Ready), 1);
    check("abort_busy", 32'(Busy), 0);
`ifdef REVERSER_PARITY_EN
    check("abort_parity", 32'(Parity), 0);
`endif
    @(negedge clk); rst = 1'b0;
    run_txn(4'b0011, 4'b0000, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
